led_pio_pwm: RTL and testbench

Parametrised Avalon-MM output PIO for board LEDs. It is the successor to the single-register LED port and adds atomic set/clear, a global PWM brightness, and per-bit blinking. It sits on the system interconnect as a slave with read latency 0 and drives the LED pins directly. Software-visible layout stays compatible at address 0, which is the plain DATA register.

---
 rtl/led_pio_pkg.sv | 24 ++
 rtl/led_pwm_timebase.sv | 67 ++++++
 rtl/led_pio_pwm.sv | 109 ++++++++++
 tb/tb_led_pio_pwm.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pio_pkg.sv
// Shared definitions for the LED PIO: register addresses, reset constants
// and the read-path zero-extension helper.
package led_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_OUTSET    = 3'd1;
  localparam logic [2:0] ADDR_OUTCLR    = 3'd2;
  localparam logic [2:0] ADDR_BLINK_EN  = 3'd3;
  localparam logic [2:0] ADDR_PRESCALE  = 3'd4;
  localparam logic [2:0] ADDR_DUTY      = 3'd5;
  localparam logic [2:0] ADDR_BLINK_DIV = 3'd6;
  localparam logic [2:0] ADDR_STATUS    = 3'd7;

  // DUTY resets to all-ones (fully on); sliced down to PWM_BITS by the user.
  localparam logic [15:0] DUTY_RESET_MAX = 16'hFFFF;

  // Keep only the low w bits of v so unused upper bits always read as 0.
  function automatic logic [31:0] zext32(input logic [31:0] v, input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return v & mask;
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler, PWM frame counter and blink phase generator for the LED PIO.
module led_pwm_timebase
  import led_pio_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PWM_BITS-1:0]   duty,
  input  logic [15:0]           blink_div,
  input  logic                  pre_clr,
  input  logic                  blink_clr,
  output logic                  pwm_on,
  output logic                  blink_phase,
  output logic [PWM_BITS-1:0]   pwm_cnt
);

  logic [PRESCALE_W-1:0] pre_cnt_reg;
  logic [PWM_BITS-1:0]   pwm_cnt_reg;
  logic [15:0]           blink_cnt_reg;
  logic                  blink_phase_reg;
  logic                  tick;
  logic                  frame_end;

  assign tick      = (pre_cnt_reg == prescale);
  assign frame_end = tick && (pwm_cnt_reg == '1);

  // Prescaler and PWM counter; a PRESCALE write restarts the prescaler at 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_cnt_reg <= '0;
      pwm_cnt_reg <= '0;
    end else begin
      if (pre_clr || tick)
        pre_cnt_reg <= '0;
      else
        pre_cnt_reg <= pre_cnt_reg + PRESCALE_W'(1);
      if (tick)
        pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
    end
  end

  // Blink divider counts PWM frames; a BLINK_DIV write clears it but keeps the phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else if (blink_clr) begin
      blink_cnt_reg <= '0;
    end else if (frame_end) begin
      if (blink_cnt_reg == blink_div) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 16'd1;
      end
    end
  end

  // All-ones duty is forced on so full brightness has no one-tick gap per frame.
  assign pwm_on      = (duty == '1) || (pwm_cnt_reg < duty);
  assign blink_phase = blink_phase_reg;
  assign pwm_cnt     = pwm_cnt_reg;

endmodule

// File: rtl/led_pio_pwm.sv
// Avalon-MM LED output port with set/clear, global PWM dimming and per-bit blink.
module led_pio_pwm
  import led_pio_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter int               PWM_BITS    = 8,
  parameter int               PRESCALE_W  = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [PWM_BITS-1:0] DUTY_RESET = DUTY_RESET_MAX[PWM_BITS-1:0];

  logic [WIDTH-1:0]      data_reg;
  logic [WIDTH-1:0]      blink_en_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [PWM_BITS-1:0]   duty_reg;
  logic [15:0]           blink_div_reg;
  logic [WIDTH-1:0]      wdata_w;
  logic [WIDTH-1:0]      out_next;
  logic                  we;
  logic                  pre_clr;
  logic                  blink_clr;
  logic                  pwm_on;
  logic                  blink_phase;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  unused_wdata;

  assign we        = chipselect && !write_n;
  assign wdata_w   = writedata[WIDTH-1:0];
  assign pre_clr   = we && (address == ADDR_PRESCALE);
  assign blink_clr = we && (address == ADDR_BLINK_DIV);
  // Upper writedata bits are legitimately ignored for narrow registers.
  assign unused_wdata = ^writedata;

  led_pwm_timebase #(
    .PWM_BITS   (PWM_BITS),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk         (clk),
    .reset_n     (reset_n),
    .prescale    (prescale_reg),
    .duty        (duty_reg),
    .blink_div   (blink_div_reg),
    .pre_clr     (pre_clr),
    .blink_clr   (blink_clr),
    .pwm_on      (pwm_on),
    .blink_phase (blink_phase),
    .pwm_cnt     (pwm_cnt)
  );

  // Register file writes; only one register can be addressed per cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_reg      <= RESET_VALUE;
      blink_en_reg  <= '0;
      prescale_reg  <= '0;
      duty_reg      <= DUTY_RESET;
      blink_div_reg <= '0;
    end else if (we) begin
      case (address)
        ADDR_DATA:      data_reg      <= wdata_w;
        ADDR_OUTSET:    data_reg      <= data_reg | wdata_w;
        ADDR_OUTCLR:    data_reg      <= data_reg & ~wdata_w;
        ADDR_BLINK_EN:  blink_en_reg  <= wdata_w;
        ADDR_PRESCALE:  prescale_reg  <= writedata[PRESCALE_W-1:0];
        ADDR_DUTY:      duty_reg      <= writedata[PWM_BITS-1:0];
        ADDR_BLINK_DIV: blink_div_reg <= writedata[15:0];
        default: ;
      endcase
    end
  end

  // Per-bit output gating: data, global PWM, and blink mask when enabled.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
    assign out_next[gi] = data_reg[gi] & pwm_on & (~blink_en_reg[gi] | blink_phase);
  end

  // LED pins are registered so they never glitch on decode or counter ripple.
  always_ff @(posedge clk) begin
    if (!reset_n)
      out_port <= '0;
    else
      out_port <= out_next;
  end

  // Zero-latency read mux; set/clear ports read back as 0.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:      readdata = zext32(32'(data_reg), WIDTH);
      ADDR_BLINK_EN:  readdata = zext32(32'(blink_en_reg), WIDTH);
      ADDR_PRESCALE:  readdata = zext32(32'(prescale_reg), PRESCALE_W);
      ADDR_DUTY:      readdata = zext32(32'(duty_reg), PWM_BITS);
      ADDR_BLINK_DIV: readdata = zext32(32'(blink_div_reg), 16);
      ADDR_STATUS:    readdata = zext32(32'({pwm_cnt, 6'd0, pwm_on, blink_phase}), PWM_BITS + 8);
      default:        readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_led_pio_pwm.sv
// Directed self-checking bench for led_pio_pwm (WIDTH=10, PWM_BITS=8, RESET_VALUE=10'h2A5).
module tb_led_pio_pwm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  int n_checks = 0;
  int n_fails  = 0;

  led_pio_pwm #(
    .WIDTH       (10),
    .PWM_BITS    (8),
    .PRESCALE_W  (16),
    .RESET_VALUE (10'h2A5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #10 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata;
    $display("read  addr=%0d data=0x%08h", a, v);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_port !== 10'h000) begin n_fails++; $display("FAIL reset_out got=0x%03h want=0x000", out_port); end
    rd(3'd7, v);
    n_checks++; if (v !== 32'h0000_0003) begin n_fails++; $display("FAIL reset_status got=0x%08h want=0x00000003", v); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (out_port !== 10'h2A5) begin n_fails++; $display("FAIL release_out got=0x%03h want=0x2a5", out_port); end
    rd(3'd5, v);
    n_checks++; if (v !== 32'h0000_00FF) begin n_fails++; $display("FAIL reset_duty got=0x%08h want=0x000000ff", v); end
    rd(3'd0, v);
    n_checks++; if (v !== 32'h0000_02A5) begin n_fails++; $display("FAIL reset_data got=0x%08h want=0x000002a5", v); end
    rd(3'd3, v);
    n_checks++; if (v !== 32'h0) begin n_fails++; $display("FAIL reset_blink_en got=0x%08h want=0", v); end
    rd(3'd4, v);
    n_checks++; if (v !== 32'h0) begin n_fails++; $display("FAIL reset_prescale got=0x%08h want=0", v); end
    rd(3'd6, v);
    n_checks++; if (v !== 32'h0) begin n_fails++; $display("FAIL reset_blink_div got=0x%08h want=0", v); end
  endtask

  task automatic test_set_clr();
    logic [31:0] v;
    wr(3'd0, 32'h0000_000F);
    n_checks++; if (out_port !== 10'h2A5) begin n_fails++; $display("FAIL data_lat got=0x%03h want=0x2a5", out_port); end
    @(negedge clk);
    n_checks++; if (out_port !== 10'h00F) begin n_fails++; $display("FAIL data_out got=0x%03h want=0x00f", out_port); end
    wr(3'd1, 32'hFFFF_F300);
    n_checks++; if (out_port !== 10'h00F) begin n_fails++; $display("FAIL set_lat got=0x%03h want=0x00f", out_port); end
    @(negedge clk);
    n_checks++; if (out_port !== 10'h30F) begin n_fails++; $display("FAIL set_out got=0x%03h want=0x30f", out_port); end
    wr(3'd2, 32'h0000_0003);
    n_checks++; if (out_port !== 10'h30F) begin n_fails++; $display("FAIL clr_lat got=0x%03h want=0x30f", out_port); end
    @(negedge clk);
    n_checks++; if (out_port !== 10'h30C) begin n_fails++; $display("FAIL clr_out got=0x%03h want=0x30c", out_port); end
    rd(3'd0, v);
    n_checks++; if (v !== 32'h0000_030C) begin n_fails++; $display("FAIL data_rb got=0x%08h want=0x0000030c", v); end
    rd(3'd1, v);
    n_checks++; if (v !== 32'h0) begin n_fails++; $display("FAIL outset_rd got=0x%08h want=0", v); end
    rd(3'd2, v);
    n_checks++; if (v !== 32'h0) begin n_fails++; $display("FAIL outclr_rd got=0x%08h want=0", v); end
  endtask

  task automatic test_pwm_duty();
    logic [31:0] v;
    int hi = 0;
    int bad = 0;
    wr(3'd4, 32'd3);
    wr(3'd5, 32'd64);
    wr(3'd0, 32'h0000_03FF);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (out_port === 10'h3FF) hi++;
      else if (out_port !== 10'h000) bad++;
    end
    $display("pwm duty=64 prescale=3: %0d high clks of 1024", hi);
    n_checks++; if (hi !== 256) begin n_fails++; $display("FAIL pwm_high got=%0d want=256", hi); end
    n_checks++; if (bad !== 0) begin n_fails++; $display("FAIL pwm_partial got=%0d want=0", bad); end
    rd(3'd5, v);
    n_checks++; if (v !== 32'd64) begin n_fails++; $display("FAIL duty_rb got=0x%08h want=0x00000040", v); end
  endtask

  task automatic test_duty_limits();
    int nz = 0;
    int off = 0;
    wr(3'd5, 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (out_port !== 10'h000) nz++;
    end
    $display("duty=0: %0d non-zero clks", nz);
    n_checks++; if (nz !== 0) begin n_fails++; $display("FAIL duty0 got=%0d want=0", nz); end
    wr(3'd5, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3072; i++) begin
      @(negedge clk);
      if (out_port !== 10'h3FF) off++;
    end
    $display("duty=255: %0d clks not fully on", off);
    n_checks++; if (off !== 0) begin n_fails++; $display("FAIL duty_full got=%0d want=0", off); end
  endtask

  task automatic test_blink();
    logic [31:0] v;
    int toggles[$];
    int phase_bad = 0;
    int bit1_bad = 0;
    logic prev_phase = 1'b0;
    logic prev_out0 = 1'b0;
    wr(3'd4, 32'd0);
    wr(3'd3, 32'h0000_0001);
    wr(3'd0, 32'h0000_0003);
    wr(3'd6, 32'd1);
    address = 3'd7;
    for (int i = 0; i < 2200; i++) begin
      @(negedge clk);
      if (i > 0 && out_port[0] !== prev_phase) phase_bad++;
      if (out_port[1] !== 1'b1) bit1_bad++;
      if (i > 0 && out_port[0] !== prev_out0) toggles.push_back(i);
      prev_phase = readdata[0];
      prev_out0  = out_port[0];
    end
    $display("blink: %0d toggles of bit 0", toggles.size());
    n_checks++; if (toggles.size() < 3) begin n_fails++; $display("FAIL blink_toggles got=%0d want>=3", toggles.size()); end
    for (int k = 1; k < toggles.size(); k++) begin
      n_checks++;
      if (toggles[k] - toggles[k-1] !== 512) begin
        n_fails++; $display("FAIL blink_period got=%0d want=512", toggles[k] - toggles[k-1]);
      end
    end
    n_checks++; if (phase_bad !== 0) begin n_fails++; $display("FAIL status_phase got=%0d mismatching clks want=0", phase_bad); end
    n_checks++; if (bit1_bad !== 0) begin n_fails++; $display("FAIL bit1_steady got=%0d low clks want=0", bit1_bad); end
    rd(3'd6, v);
    n_checks++; if (v !== 32'd1) begin n_fails++; $display("FAIL blink_div_rb got=0x%08h want=1", v); end
  endtask

  task automatic test_midframe_reset();
    logic [31:0] v;
    logic [7:0] cnt[9];
    bit found = 0;
    address = 3'd7;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (readdata[15:8] == 8'd100) found = 1;
    end
    n_checks++; if (!found) begin n_fails++; $display("FAIL midframe_wait got=timeout want=pwm_cnt 100"); end
    // Write PRESCALE=7 on the edge that also advances pwm_cnt 100->101.
    chipselect = 1'b1; write_n = 1'b0; address = 3'd4; writedata = 32'd7;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; address = 3'd7;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      cnt[k] = readdata[15:8];
    end
    $display("prescale=7 written: pwm_cnt %0d -> %0d -> %0d", cnt[0], cnt[7], cnt[8]);
    n_checks++; if (cnt[0] !== 8'd101) begin n_fails++; $display("FAIL pre_restart0 got=%0d want=101", cnt[0]); end
    n_checks++; if (cnt[7] !== 8'd101) begin n_fails++; $display("FAIL pre_restart7 got=%0d want=101", cnt[7]); end
    n_checks++; if (cnt[8] !== 8'd102) begin n_fails++; $display("FAIL pre_restart8 got=%0d want=102", cnt[8]); end
    // DATA write coincides with reset: reset must win.
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h155; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    n_checks++; if (out_port !== 10'h000) begin n_fails++; $display("FAIL rst_out got=0x%03h want=0x000", out_port); end
    rd(3'd0, v);
    n_checks++; if (v !== 32'h0000_02A5) begin n_fails++; $display("FAIL rst_data got=0x%08h want=0x000002a5", v); end
    rd(3'd7, v);
    n_checks++; if (v !== 32'h0000_0003) begin n_fails++; $display("FAIL rst_status got=0x%08h want=0x00000003", v); end
    rd(3'd4, v);
    n_checks++; if (v !== 32'h0) begin n_fails++; $display("FAIL rst_prescale got=0x%08h want=0", v); end
    rd(3'd5, v);
    n_checks++; if (v !== 32'h0000_00FF) begin n_fails++; $display("FAIL rst_duty got=0x%08h want=0x000000ff", v); end
    rd(3'd3, v);
    n_checks++; if (v !== 32'h0) begin n_fails++; $display("FAIL rst_blink_en got=0x%08h want=0", v); end
    rd(3'd6, v);
    n_checks++; if (v !== 32'h0) begin n_fails++; $display("FAIL rst_blink_div got=0x%08h want=0", v); end
    @(negedge clk);
    n_checks++; if (out_port !== 10'h2A5) begin n_fails++; $display("FAIL rst_release_out got=0x%03h want=0x2a5", out_port); end
    rd(3'd7, v);
    n_checks++; if (v !== 32'h0000_0103) begin n_fails++; $display("FAIL rst_status1 got=0x%08h want=0x00000103", v); end
  endtask

  initial begin
    test_reset();
    test_set_clr();
    test_pwm_duty();
    test_duty_limits();
    test_blink();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
